// File: rtl/vu_bar_renderer_pkg.sv
// Shared definitions for the VU meter display path: 3/3/2 colour
// constants, 640x480 timing numbers and the segment colour zone helper.
package vu_bar_renderer_pkg;

   // 8-bit RGB packed as {red[2:0], green[2:0], blue[1:0]}
   localparam logic [7:0] BLACK  = 8'b000_000_00;
   localparam logic [7:0] DIM    = 8'b000_001_00;
   localparam logic [7:0] GREEN  = 8'b000_111_00;
   localparam logic [7:0] YELLOW = 8'b111_111_00;
   localparam logic [7:0] RED    = 8'b111_000_00;
   localparam logic [7:0] WHITE  = 8'b111_111_11;

   // 640x480@60 timing, shared with the VGA timing generator
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   typedef enum logic [1:0] {
      ZONE_GREEN  = 2'd0,
      ZONE_YELLOW = 2'd1,
      ZONE_RED    = 2'd2
   } zone_e;

   // Colour zone of a segment index given the green/yellow boundaries
   function automatic zone_e zone_of(input logic [9:0] idx,
                                     input int grn_end,
                                     input int yel_end);
      zone_e z;
      if (idx < 10'(grn_end))
         z = ZONE_GREEN;
      else if (idx < 10'(yel_end))
         z = ZONE_YELLOW;
      else
         z = ZONE_RED;
      return z;
   endfunction

   // Lit colour for a zone
   function automatic logic [7:0] zone_colour(input zone_e z);
      logic [7:0] c;
      case (z)
         ZONE_GREEN:  c = GREEN;
         ZONE_YELLOW: c = YELLOW;
         default:     c = RED;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vu_bar_renderer_peak.sv
// Level bookkeeping for the VU bar: captures the incoming level, latches
// the displayed level at frame start and runs the peak-hold/decay marker.
module vu_peak_hold
   import vu_bar_renderer_pkg::*;
#(
   parameter int N_SEG     = 32,
   parameter int PEAK_HOLD = 60,
   parameter int DECAY_DIV = 4,
   parameter int LVL_W     = 6,
   parameter int CNT_W     = $clog2(N_SEG + 1)
) (
   input  logic             pixel_clock,
   input  logic             reset,
   input  logic [LVL_W-1:0] level,
   input  logic             level_valid,
   input  logic             frame_start,
   output logic [CNT_W-1:0] shown,
   output logic [CNT_W-1:0] peak
);

   localparam int HOLD_W = $clog2(PEAK_HOLD + 1);
   localparam int DEC_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

   logic [CNT_W-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0]  shown_q, shown_d;
   logic [CNT_W-1:0]  peak_q, peak_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [DEC_W-1:0]  decay_cnt_q, decay_cnt_d;

   logic [CNT_W-1:0]  level_sat;
   logic [CNT_W-1:0]  new_lvl;
   logic [CNT_W-1:0]  peak_dec;

   // Saturate the raw level to the number of segments
   always_comb begin
      if (32'(level) > N_SEG)
         level_sat = CNT_W'(N_SEG);
      else
         level_sat = CNT_W'(level);
   end

   // A strobe coinciding with frame start wins over the older pending value
   assign new_lvl  = level_valid ? level_sat : pending_q;
   assign peak_dec = peak_q - 1'b1;

   // Next-state logic: capture, frame-synchronous level/peak update
   always_comb begin
      pending_d   = pending_q;
      shown_d     = shown_q;
      peak_d      = peak_q;
      hold_cnt_d  = hold_cnt_q;
      decay_cnt_d = decay_cnt_q;
      if (level_valid)
         pending_d = level_sat;
      if (frame_start) begin
         shown_d = new_lvl;
         if (new_lvl >= peak_q) begin
            peak_d      = new_lvl;
            hold_cnt_d  = HOLD_W'(PEAK_HOLD);
            decay_cnt_d = '0;
         end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
         end else if (decay_cnt_q == DEC_W'(DECAY_DIV - 1)) begin
            // Peak is above new_lvl here, so peak_dec cannot wrap
            decay_cnt_d = '0;
            peak_d      = (peak_dec < new_lvl) ? new_lvl : peak_dec;
         end else begin
            decay_cnt_d = decay_cnt_q + 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         pending_q   <= '0;
         shown_q     <= '0;
         peak_q      <= '0;
         hold_cnt_q  <= '0;
         decay_cnt_q <= '0;
      end else begin
         pending_q   <= pending_d;
         shown_q     <= shown_d;
         peak_q      <= peak_d;
         hold_cnt_q  <= hold_cnt_d;
         decay_cnt_q <= decay_cnt_d;
      end
   end

   assign shown = shown_q;
   assign peak  = peak_q;

endmodule

// File: rtl/vu_bar_renderer.sv
// Pixel-colour source for the VU meter: one segmented horizontal bar with
// a peak marker, two-stage pipeline with syncs realigned to match.
module vu_bar_renderer
   import vu_bar_renderer_pkg::*;
#(
   parameter int N_SEG     = 32,
   parameter int SEG_W     = 20,
   parameter int GAP_W     = 4,
   parameter int BAR_TOP   = 200,
   parameter int BAR_BOT   = 280,
   parameter int GRN_END   = 20,
   parameter int YEL_END   = 26,
   parameter int PEAK_HOLD = 60,
   parameter int DECAY_DIV = 4,
   parameter int LVL_W     = 6
) (
   input  logic             pixel_clock,
   input  logic             reset,
   input  logic [9:0]       v_count,
   input  logic             active,
   input  logic             frame_start,
   input  logic             h_sync_in,
   input  logic             v_sync_in,
   input  logic [LVL_W-1:0] level,
   input  logic             level_valid,
   output logic             h_sync,
   output logic             v_sync,
   output logic [2:0]       red,
   output logic [2:0]       green,
   output logic [1:0]       blue
);

   localparam int IDX_W = 10;
   localparam int POS_W = $clog2(SEG_W + 1);
   localparam int CNT_W = $clog2(N_SEG + 1);

   logic [CNT_W-1:0] shown_w;
   logic [CNT_W-1:0] peak_w;

   vu_peak_hold #(
      .N_SEG     (N_SEG),
      .PEAK_HOLD (PEAK_HOLD),
      .DECAY_DIV (DECAY_DIV),
      .LVL_W     (LVL_W),
      .CNT_W     (CNT_W)
   ) u_peak (
      .pixel_clock (pixel_clock),
      .reset       (reset),
      .level       (level),
      .level_valid (level_valid),
      .frame_start (frame_start),
      .shown       (shown_w),
      .peak        (peak_w)
   );

   // Stage 0: segment counters describing the pixel on the inputs
   logic [IDX_W-1:0] seg_idx_q, seg_idx_d;
   logic [POS_W-1:0] seg_pos_q, seg_pos_d;

   // Stage 1 registers
   logic  lit_q, lit_d;
   logic  is_peak_q, is_peak_d;
   logic  in_bar_q, in_bar_d;
   zone_e zone_q, zone_d;
   logic  hs1_q, vs1_q;

   // Stage 2 registers
   logic [7:0] rgb_q, rgb_d;
   logic       hs2_q, vs2_q;

   // Segment counters advance across active pixels and park at 0 in blanking
   always_comb begin
      seg_idx_d = '0;
      seg_pos_d = '0;
      if (active) begin
         if (seg_pos_q == POS_W'(SEG_W - 1)) begin
            seg_pos_d = '0;
            seg_idx_d = seg_idx_q + 1'b1;
         end else begin
            seg_pos_d = seg_pos_q + 1'b1;
            seg_idx_d = seg_idx_q;
         end
      end
   end

   // Stage 1 decode: which segment, lit or not, peak marker, bar window
   always_comb begin
      lit_d     = seg_idx_q < IDX_W'(shown_w);
      is_peak_d = (peak_w != '0) && (seg_idx_q == IDX_W'(peak_w) - 1'b1);
      in_bar_d  = active
                  && (v_count >= 10'(BAR_TOP))
                  && (v_count <  10'(BAR_BOT))
                  && (seg_idx_q < IDX_W'(N_SEG))
                  && (seg_pos_q < POS_W'(SEG_W - GAP_W));
      zone_d    = zone_of(seg_idx_q, GRN_END, YEL_END);
   end

   // Stage 2 colour selection in priority order
   always_comb begin
      rgb_d = BLACK;
      if (!in_bar_q)
         rgb_d = BLACK;
      else if (is_peak_q)
         rgb_d = WHITE;
      else if (lit_q)
         rgb_d = zone_colour(zone_q);
      else
         rgb_d = DIM;
   end

   // Pipeline and counter registers
   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         seg_idx_q <= '0;
         seg_pos_q <= '0;
         lit_q     <= 1'b0;
         is_peak_q <= 1'b0;
         in_bar_q  <= 1'b0;
         zone_q    <= ZONE_GREEN;
         hs1_q     <= 1'b0;
         vs1_q     <= 1'b0;
         rgb_q     <= BLACK;
         hs2_q     <= 1'b0;
         vs2_q     <= 1'b0;
      end else begin
         seg_idx_q <= seg_idx_d;
         seg_pos_q <= seg_pos_d;
         lit_q     <= lit_d;
         is_peak_q <= is_peak_d;
         in_bar_q  <= in_bar_d;
         zone_q    <= zone_d;
         hs1_q     <= h_sync_in;
         vs1_q     <= v_sync_in;
         rgb_q     <= rgb_d;
         hs2_q     <= hs1_q;
         vs2_q     <= vs1_q;
      end
   end

   assign red    = rgb_q[7:5];
   assign green  = rgb_q[4:2];
   assign blue   = rgb_q[1:0];
   assign h_sync = hs2_q;
   assign v_sync = vs2_q;

endmodule
